// File: rtl/seq_mult_shift_add.sv
// Sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Uses an external combinational ripple-carry adder for one partial product per clock.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accepted start
// RUN   | one add/shift step per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, product valid
module seq_mult_shift_add #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_cout,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mreg;
   logic [CW-1:0]      count;

   assign add_a = acc[2*WIDTH-1:WIDTH];
   assign add_b = mreg;

   // carry-out shifts into the MSB, so the running sum never overflows
   always_comb begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
      if (acc[0])
         acc_next = {add_cout, add_sum, acc[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         mreg    <= '0;
         count   <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  mreg  <= multiplicand;
                  acc   <= {{WIDTH{1'b0}}, multiplier};
                  count <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_next;
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  product <= acc_next;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Directed bench for seq_mult_shift_add with a behavioural 4-bit adder attached.
// Table-driven products plus hand sequences for ignored starts and mid-run reset.
module tb_seq_mult_shift_add;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic             busy;
   logic             done;
   logic [7:0]       product;

   int passed;
   int total;
   logic [7:0] prev_prod;

   seq_mult_shift_add #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_sum      (add_sum),
      .add_cout     (add_cout),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] m;
      logic [3:0] q;
      logic [7:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Returns the number of edges seen since the start edge when done appears.
   task automatic wait_done(input string name, input int edges_in, output int edges_out);
      int e;
      e = edges_in;
      while (!done && e < 12) begin
         @(negedge clk);
         e++;
      end
      if (!done) check({name, "_timeout"}, 16'(done), 16'd1);
      edges_out = e;
   endtask

   task automatic run_mult(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                           input string tag);
      int edges;
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      multiplicand = ~m;
      multiplier   = ~q;
      check({tag, "_busy_run"}, 16'(busy), 16'd1);
      check({tag, "_add_b"}, 16'(add_b), 16'(m));
      check({tag, "_prod_held"}, 16'(product), 16'(prev_prod));
      wait_done(tag, 1, edges);
      check({tag, "_latency"}, 16'(edges), 16'(WIDTH + 1));
      check({tag, "_product"}, 16'(product), 16'(exp));
      check({tag, "_busy_done"}, 16'(busy), 16'd1);
      @(negedge clk);
      check({tag, "_idle"}, 16'({busy, done}), 16'd0);
      prev_prod = exp;
   endtask

   vec_t vecs[8];

   initial begin
      int edges;
      passed = 0;
      total  = 0;
      prev_prod = 8'h00;
      vecs[0] = '{4'd3,  4'd5,  8'h0F};
      vecs[1] = '{4'd15, 4'd15, 8'hE1};
      vecs[2] = '{4'd0,  4'd9,  8'h00};
      vecs[3] = '{4'd9,  4'd0,  8'h00};
      vecs[4] = '{4'd1,  4'd1,  8'h01};
      vecs[5] = '{4'd5,  4'd4,  8'h14};
      vecs[6] = '{4'd10, 4'd13, 8'h82};
      vecs[7] = '{4'd6,  4'd7,  8'h2A};

      rst_n = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy",    16'(busy),    16'd0);
      check("rst_done",    16'(done),    16'd0);
      check("rst_product", 16'(product), 16'd0);
      check("rst_add_ab",  16'({add_a, add_b}), 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 15x15: watch the carry shift into the accumulator top
      multiplicand = 4'd15;
      multiplier   = 4'd15;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ff_add_a0", 16'(add_a), 16'h0);
      check("ff_add_b",  16'(add_b), 16'hF);
      @(negedge clk);
      check("ff_add_a1", 16'(add_a), 16'h7);
      @(negedge clk);
      check("ff_add_a2", 16'(add_a), 16'hB);
      wait_done("ff", 3, edges);
      check("ff_latency", 16'(edges), 16'(WIDTH + 1));
      check("ff_product", 16'(product), 16'hE1);
      @(negedge clk);
      prev_prod = 8'hE1;

      for (int i = 0; i < 8; i++)
         run_mult(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));

      // start re-asserted during RUN and DONE is ignored; start held into IDLE is accepted
      multiplicand = 4'd7;
      multiplier   = 4'd6;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      multiplicand = 4'd2;
      multiplier   = 4'd2;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_add_b_run", 16'(add_b), 16'd7);
      wait_done("ign", 3, edges);
      check("ign_latency", 16'(edges), 16'(WIDTH + 1));
      check("ign_product", 16'(product), 16'h2A);
      start = 1'b1;
      @(negedge clk);
      check("ign_idle_after_done", 16'(busy), 16'd0);
      check("ign_prod_hold", 16'(product), 16'h2A);
      @(negedge clk);
      start = 1'b0;
      check("ign_accept_busy", 16'(busy), 16'd1);
      check("ign_accept_add_b", 16'(add_b), 16'd2);
      wait_done("ign2", 1, edges);
      check("ign2_product", 16'(product), 16'h04);
      @(negedge clk);

      // reset on the second RUN cycle aborts without a done pulse
      multiplicand = 4'd12;
      multiplier   = 4'd11;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy",    16'(busy),    16'd0);
      check("abort_done",    16'(done),    16'd0);
      check("abort_product", 16'(product), 16'd0);
      check("abort_add_ab",  16'({add_a, add_b}), 16'd0);
      edges = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) edges++;
      end
      check("abort_no_done", 16'(edges), 16'd0);
      prev_prod = 8'h00;
      run_mult(4'd2, 4'd3, 8'h06, "post_abort");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
